// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : shared constants, FSM state encoding and parity helper for uart_tx
// Build option: UART_TX_PARITY_EN inserts an even-parity bit after D7.
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int IDX_BITS  = $clog2(DATA_BITS);
  localparam logic [IDX_BITS-1:0] LAST_BIT = IDX_BITS'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================================
// uart_tx_fifo : synchronous byte FIFO, 2**ADDR_BITS deep, with occupancy count
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
  parameter int ADDR_BITS = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [7:0]           din,
  input  logic                 pop,
  output logic [7:0]           dout,
  output logic [ADDR_BITS:0]   count,
  output logic                 full,
  output logic                 empty
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] PTR_ONE = 1;
  localparam logic [ADDR_BITS:0]   CNT_ONE = 1;

  logic [7:0]           r_mem [DEPTH];
  logic [ADDR_BITS-1:0] r_wr_ptr;
  logic [ADDR_BITS-1:0] r_rd_ptr;
  logic [ADDR_BITS:0]   r_count;
  logic                 w_do_push;
  logic                 w_do_pop;

  assign full      = (r_count == (ADDR_BITS+1)'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign count     = r_count;
  assign dout      = r_mem[r_rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
// ============================================================================
// uart_tx : buffered 8-bit LSB-first UART transmitter, one stop bit
// Build option: UART_TX_PARITY_EN adds an even-parity bit (11-bit frame).
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int ADDR_BITS = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 uart_txd,
  output logic                 busy,
  output logic [ADDR_BITS:0]   fifo_count
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int TIMER_BITS   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TIMER_BITS-1:0] TIMER_MAX = TIMER_BITS'(CLKS_PER_BIT - 1);
  localparam logic [TIMER_BITS-1:0] TIMER_ONE = 1;
  localparam logic [IDX_BITS-1:0]   IDX_ONE   = 1;

  tx_state_t             r_state;
  tx_state_t             w_next_state;
  logic [TIMER_BITS-1:0] r_timer;
  logic [IDX_BITS-1:0]   r_bit_idx;
  logic [DATA_BITS-1:0]  r_shift;
  logic                  r_txd;
  logic                  w_txd;
  logic                  w_pop;
  logic                  w_tick;
  logic [7:0]            w_fifo_dout;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
`ifdef UART_TX_PARITY_EN
  logic                  r_parity;
`endif

  uart_tx_fifo #(
    .ADDR_BITS (ADDR_BITS)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_valid),
    .din   (tx_data),
    .pop   (w_pop),
    .dout  (w_fifo_dout),
    .count (fifo_count),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

  assign w_tick   = (r_timer == TIMER_MAX);
  assign tx_ready = !w_fifo_full;
  assign busy     = (r_state != ST_IDLE) || !w_fifo_empty;
  assign uart_txd = r_txd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (!w_fifo_empty) w_next_state = ST_START;
      ST_START: if (w_tick) w_next_state = ST_DATA;
      ST_DATA: begin
        if (w_tick && (r_bit_idx == LAST_BIT)) begin
`ifdef UART_TX_PARITY_EN
          w_next_state = ST_PARITY;
`else
          w_next_state = ST_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: if (w_tick) w_next_state = ST_STOP;
`endif
      ST_STOP:  if (w_tick) w_next_state = w_fifo_empty ? ST_IDLE : ST_START;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // A pop coincides with entering START, from IDLE or straight out of STOP.
  always_comb begin
    w_pop = 1'b0;
    w_txd = 1'b1;
    case (r_state)
      ST_IDLE:   w_pop = !w_fifo_empty;
      ST_START:  w_txd = 1'b0;
      ST_DATA:   w_txd = r_shift[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: w_txd = r_parity;
`endif
      ST_STOP:   w_pop = w_tick && !w_fifo_empty;
      default:   w_txd = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timer   <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
`ifdef UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else if (w_pop) begin
      r_timer   <= '0;
      r_bit_idx <= '0;
      r_shift   <= w_fifo_dout;
`ifdef UART_TX_PARITY_EN
      r_parity  <= even_parity(w_fifo_dout);
`endif
    end else if (r_state != ST_IDLE) begin
      if (w_tick) begin
        r_timer <= '0;
        if (r_state == ST_DATA) begin
          r_shift   <= r_shift >> 1;
          r_bit_idx <= r_bit_idx + IDX_ONE;
        end
      end else begin
        r_timer <= r_timer + TIMER_ONE;
      end
    end
  end

  // Registered line output keeps the pin glitch-free; reset forces idle high at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_txd <= 1'b1;
    else       r_txd <= w_txd;
  end

endmodule

`default_nettype wire
